multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style multi-cycle control unit for the Lapido 32-bit datapath.
- Sequences the instruction phases: fetch, decode, execute, memory and writeback.
- Drives the datapath mux/enable lines, including the immediate extension mode (sign vs zero) consumed by the immediate extender.
- Handshakes with the memory interface and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of retired-instruction counter (wraps modulo 2^COUNT_WIDTH).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction register bits [31:26], valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request strobe, held until mem_ready
- mem_we  out  1  1 = write request (with mem_req)
- iord  out  1  0 = address from PC, 1 = ALU result register
- ir_write  out  1  load instruction register
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when zero=1
- pc_source  out  2  00 ALU result, 01 ALU out register (branch target), 10 jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 extended imm, 11 extended imm << 2
- alu_op  out  3  000 add, 001 sub, 010 use funct, 011 and, 100 or
- ext_sign  out  1  1 = sign-extend imm[15:0], 0 = zero-extend
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  writeback from memory data register
- reg_write  out  1  register file write enable
- illegal  out  1  one-cycle pulse, unknown opcode
- retired  out  1  one-cycle pulse, instruction completed
- instr_count  out  COUNT_WIDTH  retired instruction count
- state  out  4  current state code (debug)

Behaviour:
- Reset (async, rst_n=0): state=FETCH, instr_count=0, op_q=0, every output 0, and mem_req=0 immediately, including mid-transaction. Only after rst_n rises does the first FETCH assert mem_req, on the next edge.
- Opcode set:
  - R-type 000000
  - addi 001000 (sign)
  - andi 001100 (zero)
  - ori 001101 (zero)
  - lw 100011 (sign)
  - sw 101011 (sign)
  - beq 000100 (sign)
  - j 000010
- Opcode latch: op_q is latched from opcode on the DECODE cycle. ext_sign is decoded from op_q; it is 0 for andi/ori and 1 otherwise. In DECODE it is decoded from the live opcode.
- States (code) and transitions:
  - FETCH(0): mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add. On mem_ready: ir_write=1, pc_write=1, pc_source=00, then go to DECODE. Otherwise hold with ir_write=pc_write=0.
  - DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=add (branch target). Next state: R-type->EXEC_R; addi/andi/ori->EXEC_I; lw/sw->MEM_ADDR; beq->BRANCH; j->JUMP. Any other opcode: illegal=1 and go to FETCH; not retired, count unchanged.
  - MEM_ADDR(2): alu_src_a=1, alu_src_b=10, add. lw->MEM_READ; sw->MEM_WRITE.
  - MEM_READ(3): mem_req=1, iord=1. Hold until mem_ready, then go to MEM_WB.
  - MEM_WB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Retire, then FETCH.
  - MEM_WRITE(5): mem_req=1, mem_we=1, iord=1. Hold until mem_ready, then retire and go to FETCH.
  - EXEC_R(6): alu_src_a=1, alu_src_b=00, alu_op=010. Then R_WB.
  - R_WB(7): reg_write=1, reg_dst=1. Retire, then FETCH.
  - EXEC_I(8): alu_src_a=1, alu_src_b=10, alu_op=add/and/or per op_q. Then I_WB.
  - I_WB(9): reg_write=1, reg_dst=0. Retire, then FETCH.
  - BRANCH(10): alu_src_a=1, alu_src_b=00, alu_op=sub, pc_write_cond=1, pc_source=01. Retire, then FETCH.
  - JUMP(11): pc_write=1, pc_source=10. Retire, then FETCH.
  - Codes 12–15 are unreachable; if entered, go to FETCH with all outputs 0.
- Cycle latencies with zero memory wait (mem_ready=1 on the first request cycle):
  - lw: 5 cycles
  - R-type, addi/andi/ori, sw: 4 cycles
  - beq, j: 3 cycles
  - Each wait cycle adds one cycle.
- Memory request rules: mem_req stays high and constant, with iord and mem_we stable, for the whole wait. mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Retirement: retired pulses in the final state's cycle. instr_count increments on that cycle's edge and wraps from all-ones to 0.
- Outputs not listed for a state are 0.

Test Plan:
- Reset: rst_n low mid-MEM_READ with mem_req=1 -> mem_req=0 immediately; state=0 and instr_count=0. After release, FETCH asserts mem_req on the next edge.
- addi (opcode 001000), mem_ready tied 1 -> states 0,1,8,9. ext_sign=1 in DECODE and EXEC_I. reg_write=1 only in I_WB. retired once; instr_count=1.
- ori (001101) then andi (001100) -> ext_sign=0 and alu_op=100 then 011 in EXEC_I; instr_count=2 after 8 cycles.
- lw with mem_ready low for 3 cycles in FETCH and 2 in MEM_READ -> total 10 cycles. mem_req stays continuously high with iord=0 then iord=1. ir_write pulses exactly once.
- beq with zero=1 -> pc_write_cond=1, pc_source=01 in state 10; 3 cycles. j -> pc_write=1, pc_source=10 in state 11.
- Opcode 111111 -> illegal pulses in DECODE, return to FETCH, instr_count unchanged. Preload count to all-ones, then retire an R-type -> count wraps to 0.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for the Lapido 32-bit datapath: sequences fetch/decode/execute/
// memory/writeback, drives datapath controls, handshakes with memory, counts retirements.
module multicycle_control #(
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [5:0]             opcode,
    input  logic                   zero,
    input  logic                   mem_ready,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic                   iord,
    output logic                   ir_write,
    output logic                   pc_write,
    output logic                   pc_write_cond,
    output logic [1:0]             pc_source,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic [2:0]             alu_op,
    output logic                   ext_sign,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   reg_write,
    output logic                   illegal,
    output logic                   retired,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_R_WB      = 4'd7,
        S_EXEC_I    = 4'd8,
        S_I_WB      = 4'd9,
        S_BRANCH    = 4'd10,
        S_JUMP      = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    function automatic logic sign_ext_of(input logic [5:0] op);
        return !((op == OP_ANDI) || (op == OP_ORI));
    endfunction

    state_t     state_q, state_d;
    logic [5:0] op_q, op_sel;
    logic       pc_write_q, retire_q;
    logic       mem_req_d, mem_we_d, iord_d, pc_write_d, pc_write_cond_d;
    logic [1:0] pc_source_d, alu_src_b_d;
    logic       alu_src_a_d, reg_dst_d, mem_to_reg_d, reg_write_d, retire_d;
    logic [2:0] alu_op_d;
    logic       fetch_done;
    logic       unused_zero;

    // zero is consumed by the datapath together with pc_write_cond
    assign unused_zero = zero;

    // Next state, plus the registered outputs decoded from the state being entered
    always_comb begin
        state_d         = state_q;
        op_sel          = (state_q == S_DECODE) ? opcode : op_q;
        mem_req_d       = 1'b0;
        mem_we_d        = 1'b0;
        iord_d          = 1'b0;
        pc_write_d      = 1'b0;
        pc_write_cond_d = 1'b0;
        pc_source_d     = 2'b00;
        alu_src_a_d     = 1'b0;
        alu_src_b_d     = 2'b00;
        alu_op_d        = 3'b000;
        reg_dst_d       = 1'b0;
        mem_to_reg_d    = 1'b0;
        reg_write_d     = 1'b0;
        retire_d        = 1'b0;

        case (state_q)
            S_FETCH:     if (mem_req && mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:                  state_d = S_EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_EXEC_I;
                    OP_LW, OP_SW:              state_d = S_MEM_ADDR;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    default:                   state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
            S_EXEC_R:    state_d = S_R_WB;
            S_EXEC_I:    state_d = S_I_WB;
            default:     state_d = S_FETCH;
        endcase

        case (state_d)
            S_FETCH: begin
                mem_req_d   = 1'b1;
                alu_src_b_d = 2'b01;
            end
            S_DECODE:    alu_src_b_d = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
            end
            S_MEM_READ: begin
                mem_req_d = 1'b1;
                iord_d    = 1'b1;
            end
            S_MEM_WB: begin
                reg_write_d  = 1'b1;
                mem_to_reg_d = 1'b1;
                retire_d     = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_req_d = 1'b1;
                mem_we_d  = 1'b1;
                iord_d    = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a_d = 1'b1;
                alu_op_d    = 3'b010;
            end
            S_R_WB: begin
                reg_write_d = 1'b1;
                reg_dst_d   = 1'b1;
                retire_d    = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_d = 1'b1;
                alu_src_b_d = 2'b10;
                alu_op_d    = (op_sel == OP_ANDI) ? 3'b011 :
                              (op_sel == OP_ORI)  ? 3'b100 : 3'b000;
            end
            S_I_WB: begin
                reg_write_d = 1'b1;
                retire_d    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_d     = 1'b1;
                alu_op_d        = 3'b001;
                pc_write_cond_d = 1'b1;
                pc_source_d     = 2'b01;
                retire_d        = 1'b1;
            end
            S_JUMP: begin
                pc_write_d  = 1'b1;
                pc_source_d = 2'b10;
                retire_d    = 1'b1;
            end
            default: ;
        endcase
    end

    // Handshake- and opcode-qualified strobes must react within the current cycle
    assign fetch_done = (state_q == S_FETCH) && mem_req && mem_ready;
    assign ir_write   = fetch_done;
    assign pc_write   = fetch_done || pc_write_q;
    assign retired    = retire_q || ((state_q == S_MEM_WRITE) && mem_ready);
    assign illegal    = (state_q == S_DECODE) &&
                        !(opcode inside {OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
                                         OP_LW, OP_SW, OP_BEQ, OP_J});
    assign ext_sign   = (state_q == S_DECODE) ? sign_ext_of(opcode) :
                        ((state_q == S_FETCH) || (state_q > S_JUMP)) ? 1'b0 :
                        sign_ext_of(op_q);
    assign state      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            op_q          <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            iord          <= 1'b0;
            pc_write_q    <= 1'b0;
            pc_write_cond <= 1'b0;
            pc_source     <= 2'b00;
            alu_src_a     <= 1'b0;
            alu_src_b     <= 2'b00;
            alu_op        <= 3'b000;
            reg_dst       <= 1'b0;
            mem_to_reg    <= 1'b0;
            reg_write     <= 1'b0;
            retire_q      <= 1'b0;
            instr_count   <= '0;
        end else begin
            state_q       <= state_d;
            if (state_q == S_DECODE) op_q <= opcode;
            mem_req       <= mem_req_d;
            mem_we        <= mem_we_d;
            iord          <= iord_d;
            pc_write_q    <= pc_write_d;
            pc_write_cond <= pc_write_cond_d;
            pc_source     <= pc_source_d;
            alu_src_a     <= alu_src_a_d;
            alu_src_b     <= alu_src_b_d;
            alu_op        <= alu_op_d;
            reg_dst       <= reg_dst_d;
            mem_to_reg    <= mem_to_reg_d;
            reg_write     <= reg_write_d;
            retire_q      <= retire_d;
            if (retired) instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues per-cycle expected controls,
// a negedge monitor pops and compares them against the DUT.
module tb_multicycle_control;

    localparam int unsigned CW = 4;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic [3:0]    st;
        logic          mreq, mwe, iord, irw, pcw, pcwc;
        logic [1:0]    psrc;
        logic          asa;
        logic [1:0]    asb;
        logic [2:0]    aop;
        logic          exts, rdst, m2r, rw, ill, ret;
        logic [CW-1:0] cnt;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [5:0]    opcode;
    logic          zero, mem_ready;
    logic          mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0]    pc_source, alu_src_b;
    logic          alu_src_a, ext_sign, reg_dst, mem_to_reg, reg_write, illegal, retired;
    logic [2:0]    alu_op;
    logic [CW-1:0] instr_count;
    logic [3:0]    state;

    int            checks = 0;
    int            errors = 0;
    rec_t          q[$];
    logic [5:0]    cur_op = 6'b0;
    logic [CW-1:0] cnt_model = '0;

    multicycle_control #(.COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_sign(ext_sign),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal(illegal), .retired(retired), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    // Expected control word for one cycle in a given state
    function automatic rec_t exp_rec(input logic [3:0] st, input logic [5:0] op,
                                     input logic rdy, input logic [CW-1:0] c);
        rec_t r;
        r     = '0;
        r.st  = st;
        r.cnt = c;
        if (st != 4'd0) r.exts = !((op == OP_ANDI) || (op == OP_ORI));
        case (st)
            4'd0: begin r.mreq = 1'b1; r.asb = 2'b01; r.irw = rdy; r.pcw = rdy; end
            4'd1: begin
                r.asb = 2'b11;
                r.ill = !(op inside {OP_R, OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ, OP_J});
            end
            4'd2: begin r.asa = 1'b1; r.asb = 2'b10; end
            4'd3: begin r.mreq = 1'b1; r.iord = 1'b1; end
            4'd4: begin r.rw = 1'b1; r.m2r = 1'b1; r.ret = 1'b1; end
            4'd5: begin r.mreq = 1'b1; r.mwe = 1'b1; r.iord = 1'b1; r.ret = rdy; end
            4'd6: begin r.asa = 1'b1; r.aop = 3'b010; end
            4'd7: begin r.rw = 1'b1; r.rdst = 1'b1; r.ret = 1'b1; end
            4'd8: begin
                r.asa = 1'b1; r.asb = 2'b10;
                r.aop = (op == OP_ANDI) ? 3'b011 : (op == OP_ORI) ? 3'b100 : 3'b000;
            end
            4'd9:  begin r.rw = 1'b1; r.ret = 1'b1; end
            4'd10: begin r.asa = 1'b1; r.aop = 3'b001; r.pcwc = 1'b1; r.psrc = 2'b01; r.ret = 1'b1; end
            4'd11: begin r.pcw = 1'b1; r.psrc = 2'b10; r.ret = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic rec_t act_rec();
        rec_t a;
        a.st = state;  a.mreq = mem_req; a.mwe = mem_we; a.iord = iord; a.irw = ir_write;
        a.pcw = pc_write; a.pcwc = pc_write_cond; a.psrc = pc_source; a.asa = alu_src_a;
        a.asb = alu_src_b; a.aop = alu_op; a.exts = ext_sign; a.rdst = reg_dst;
        a.m2r = mem_to_reg; a.rw = reg_write; a.ill = illegal; a.ret = retired;
        a.cnt = instr_count;
        return a;
    endfunction

    // Monitor: compare every cycle for which the stimulus queued an expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            rec_t e, a;
            e = q.pop_front();
            a = act_rec();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL trace st=%0d got=%h expected=%h", e.st, a, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_op(input logic [5:0] op);
        cur_op = op;
        opcode = op;
    endtask

    task automatic cyc(input logic [3:0] st, input logic rdy);
        mem_ready = rdy;
        q.push_back(exp_rec(st, cur_op, rdy, cnt_model));
        @(posedge clk);
        #1;
        if ((st inside {4'd4, 4'd7, 4'd9, 4'd10, 4'd11}) || (st == 4'd5 && rdy))
            cnt_model = cnt_model + CW'(1);
    endtask

    // First cycle after reset release: still all-zero, mem_ready must be ignored
    task automatic idle_cyc(input logic rdy);
        rec_t r;
        mem_ready = rdy;
        r         = '0;
        r.cnt     = cnt_model;
        q.push_back(r);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'b0, mem_req, state}, 32'h0);
        check("reset_count", 32'(instr_count), 32'h0);
        rst_n = 1'b1;
        idle_cyc(1'b1);

        set_op(OP_ADDI); cyc(0, 1); cyc(1, 1); cyc(8, 1); cyc(9, 1);
        set_op(OP_ORI);  cyc(0, 1); cyc(1, 1); cyc(8, 1); cyc(9, 1);
        set_op(OP_ANDI); cyc(0, 1); cyc(1, 1); cyc(8, 1); cyc(9, 1);

        // lw: 3 fetch waits, 2 read waits -> 10 cycles
        set_op(OP_LW);
        cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 1);
        cyc(1, 0); cyc(2, 0); cyc(3, 0); cyc(3, 0); cyc(3, 1); cyc(4, 0);

        set_op(OP_SW);  cyc(0, 1); cyc(1, 1); cyc(2, 1); cyc(5, 0); cyc(5, 1);
        zero = 1'b1;
        set_op(OP_BEQ); cyc(0, 1); cyc(1, 1); cyc(10, 1);
        zero = 1'b0;
        set_op(OP_J);   cyc(0, 1); cyc(1, 1); cyc(11, 0);
        set_op(OP_BAD); cyc(0, 1); cyc(1, 1);

        for (int i = 0; i < 8; i++) begin
            set_op(OP_J); cyc(0, 1); cyc(1, 1); cyc(11, 1);
        end
        // count is now all-ones; this R-type wraps it to zero
        set_op(OP_R); cyc(0, 1); cyc(1, 0); cyc(6, 1); cyc(7, 1);
        cyc(0, 0);

        // Reset in the middle of a memory read
        set_op(OP_LW); cyc(0, 1); cyc(1, 1); cyc(2, 1);
        mem_ready = 1'b0;
        #2;
        check("pre_reset_read", {27'b0, mem_req, state}, 32'h13);
        rst_n = 1'b0;
        #1;
        check("async_reset_req", {27'b0, mem_req, state}, 32'h0);
        check("async_reset_count", 32'(instr_count), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cnt_model = '0;
        idle_cyc(1'b0);
        cyc(0, 0); cyc(0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
